// File: rtl/mem_pkg.sv
// Shared types and constants for the memory access stage: access size
// encoding, FSM states, bus timeout and the lane offset helper.
package mem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    // REQ cycles without an ack before the access is abandoned as a bus error
    localparam int TIMEOUT_CYCLES = 15;
    localparam int TMO_W          = 4;

    // Effective byte lane of an access: low address bits that the size
    // does not allow are treated as zero.
    function automatic logic [1:0] lane_offset(input logic [1:0] size,
                                               input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return addr_lo;
            SIZE_HALF: return {addr_lo[1], 1'b0};
            default:   return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/define.sv
// Global width definitions for the memory access stage.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

// File: rtl/load_extend.sv
// load_extend: picks the addressed byte/half out of a read word and
// sign- or zero-extends it to the full data width.
`include "define.sv"
module load_extend
    import mem_pkg::*;
(
    input  logic [`DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]             i_off,
    input  logic [1:0]             i_size,
    input  logic                   i_unsigned,
    output logic [`DATA_WIDTH-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select followed by extension according to size and signedness
    always_comb begin
        w_byte = i_rdata[8*i_off +: 8];
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_size)
            SIZE_BYTE: o_data = {{(`DATA_WIDTH-8){~i_unsigned & w_byte[7]}}, w_byte};
            SIZE_HALF: o_data = {{(`DATA_WIDTH-16){~i_unsigned & w_half[15]}}, w_half};
            default:   o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage. Turns load/store instructions into a
// req/ack data-memory transaction (IDLE -> REQ -> RESP), stalling the
// upstream stages while the bus is busy, with a bus-error timeout.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned accesses are
// rejected with an o_misalign pulse instead of being issued.
`include "define.sv"
module mem_access
    import mem_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic                   i_memread,
    input  logic                   i_memwrite,
    input  logic [1:0]             i_size,
    input  logic                   i_unsigned,
    input  logic [`DATA_WIDTH-1:0] i_alures,
    input  logic [`DATA_WIDTH-1:0] i_wdata,
    input  logic [1:0]             i_WB,
    input  logic [4:0]             i_we,
    output logic [1:0]             o_WB,
    output logic [`DATA_WIDTH-1:0] o_dataread,
    output logic [`DATA_WIDTH-1:0] o_alures,
    output logic [4:0]             o_we,
    output logic                   o_stall,
    output logic                   o_misalign,
    output logic                   o_buserr,
    output logic                   mem_req,
    output logic                   mem_wr,
    output logic [`DATA_WIDTH-1:0] mem_addr,
    output logic [3:0]             mem_be,
    output logic [`DATA_WIDTH-1:0] mem_wdata,
    input  logic [`DATA_WIDTH-1:0] mem_rdata,
    input  logic                   mem_ack
);

    state_e                 r_state;
    state_e                 w_state_next;
    logic [`DATA_WIDTH-1:0] r_addr;
    logic [3:0]             r_be;
    logic [`DATA_WIDTH-1:0] r_wdata;
    logic                   r_wr;
    logic [1:0]             r_off;
    logic [1:0]             r_size;
    logic                   r_unsigned;
    logic [TMO_W-1:0]       r_cnt;
    logic [`DATA_WIDTH-1:0] r_rdata;
    logic                   r_err;
    logic                   r_buserr;

    size_e                  w_size;
    logic [1:0]             w_off;
    logic                   w_mem_op;
    logic                   w_start;
    logic                   w_misalign_hit;
    logic                   w_timeout;
    logic [3:0]             w_be;
    logic [`DATA_WIDTH-1:0] w_wdata;
    logic [`DATA_WIDTH-1:0] w_load_data;

    assign w_size   = size_e'(i_size);
    assign w_off    = lane_offset(i_size, i_alures[1:0]);
    assign w_mem_op = i_valid & (i_memread | i_memwrite);

`ifdef MEM_ALIGN_CHECK_EN
    logic w_misaligned;
    logic r_misalign;

    assign w_misaligned   = ((w_size == SIZE_WORD) && (i_alures[1:0] != 2'b00)) ||
                            ((w_size == SIZE_HALF) && i_alures[0]);
    assign w_start        = w_mem_op & ~w_misaligned;
    assign w_misalign_hit = w_mem_op & w_misaligned;
    assign o_misalign     = r_misalign;

    // One-cycle pulse for a rejected misaligned access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_misalign <= 1'b0;
        else     r_misalign <= (r_state == IDLE) & w_misalign_hit;
    end
`else
    assign w_start        = w_mem_op;
    assign w_misalign_hit = 1'b0;
    assign o_misalign     = 1'b0;
`endif

    // Per-lane store data replication and byte enables
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_wdata[8*gi +: 8] = (w_size == SIZE_BYTE) ? i_wdata[7:0] :
                                        (w_size == SIZE_HALF) ? i_wdata[8*(gi%2) +: 8] :
                                                                i_wdata[8*gi +: 8];
            assign w_be[gi] = (w_size == SIZE_BYTE) ? (w_off == 2'(gi)) :
                              (w_size == SIZE_HALF) ? (w_off[1] == (gi >= 2)) :
                                                      1'b1;
        end
    endgenerate

    load_extend u_load_extend (
        .i_rdata    (mem_rdata),
        .i_off      (r_off),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_load_data)
    );

    assign o_alures  = i_alures;
    assign o_we      = i_we;
    assign o_buserr  = r_buserr;
    assign mem_req   = (r_state == REQ);
    assign mem_wr    = (r_state == REQ) & r_wr;
    assign mem_be    = (r_state == REQ) ? r_be : 4'b0000;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next state and pipeline-side outputs
    always_comb begin
        w_state_next = r_state;
        w_timeout    = 1'b0;
        o_stall      = 1'b0;
        o_WB         = i_WB;
        o_dataread   = '0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    o_stall      = 1'b1;
                    o_WB         = 2'b00;
                    w_state_next = REQ;
                end else if (w_misalign_hit) begin
                    o_WB = 2'b00;
                end
            end
            REQ: begin
                o_stall = 1'b1;
                o_WB    = 2'b00;
                if (mem_ack) begin
                    w_state_next = RESP;
                end else if (r_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout    = 1'b1;
                    w_state_next = RESP;
                end
            end
            RESP: begin
                o_dataread   = r_rdata;
                o_WB         = r_err ? 2'b00 : i_WB;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Request latch at issue, REQ cycle counting, response capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_be       <= 4'b0000;
            r_wdata    <= '0;
            r_wr       <= 1'b0;
            r_off      <= 2'b00;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_cnt      <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_buserr   <= 1'b0;
        end else begin
            r_buserr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_addr     <= {i_alures[`DATA_WIDTH-1:2], 2'b00};
                        r_be       <= w_be;
                        r_wdata    <= w_wdata;
                        r_wr       <= i_memwrite;
                        r_off      <= w_off;
                        r_size     <= i_size;
                        r_unsigned <= i_unsigned;
                        r_cnt      <= '0;
                        r_rdata    <= '0;
                        r_err      <= 1'b0;
                    end
                end
                REQ: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (mem_ack) begin
                        r_rdata <= r_wr ? '0 : w_load_data;
                    end else if (w_timeout) begin
                        r_rdata  <= '0;
                        r_err    <= 1'b1;
                        r_buserr <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized bench for mem_access with a behavioural model
// of lane selection, extension, store replication and bus timing.
// Build macro MEM_ALIGN_CHECK_EN selects the misaligned-access behaviour.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_memread, i_memwrite, i_unsigned;
    logic [1:0]  i_size, i_WB;
    logic [31:0] i_alures, i_wdata;
    logic [4:0]  i_we;
    logic [1:0]  o_WB;
    logic [31:0] o_dataread, o_alures;
    logic [4:0]  o_we;
    logic        o_stall, o_misalign, o_buserr;
    logic        mem_req, mem_wr, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int n_vec = 0;
    int n_err = 0;
    int n_txn = 0;

    mem_access dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_memread  (i_memread),
        .i_memwrite (i_memwrite),
        .i_size     (i_size),
        .i_unsigned (i_unsigned),
        .i_alures   (i_alures),
        .i_wdata    (i_wdata),
        .i_WB       (i_WB),
        .i_we       (i_we),
        .o_WB       (o_WB),
        .o_dataread (o_dataread),
        .o_alures   (o_alures),
        .o_we       (o_we),
        .o_stall    (o_stall),
        .o_misalign (o_misalign),
        .o_buserr   (o_buserr),
        .mem_req    (mem_req),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int eff_off(input int sz, input logic [31:0] addr);
        if (sz == 0) return int'(addr % 4);
        if (sz == 1) return int'(addr % 4) / 2 * 2;
        return 0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rd, input int sz,
                                             input bit uns, input logic [31:0] addr);
        logic [31:0] v;
        v = rd >> (8 * eff_off(sz, addr));
        if (sz == 0) begin
            v = v & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (sz == 1) begin
            v = v & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_be(input int sz, input logic [31:0] addr);
        if (sz == 0) return 32'd1 << eff_off(sz, addr);
        if (sz == 1) return 32'd3 << eff_off(sz, addr);
        return 32'd15;
    endfunction

    function automatic logic [31:0] exp_wdata(input int sz, input logic [31:0] wd);
        if (sz == 0) return (wd & 32'hFF) * 32'h01010101;
        if (sz == 1) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    task automatic idle_inputs();
        i_valid = 0; i_memread = 0; i_memwrite = 0; i_size = 0; i_unsigned = 0;
        i_alures = 0; i_wdata = 0; i_WB = 0; i_we = 0; mem_ack = 0; mem_rdata = 0;
    endtask

    // One full memory transaction; ack_at >= 15 means the bus never answers
    task automatic run_mem(input bit wr, input bit rd, input int sz, input bit uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int ack_at,
                           input logic [1:0] wb, input logic [4:0] we);
        int  stalls;
        bit  tmo;
        stalls = 0;
        tmo = (ack_at >= 15);
        @(posedge clk); #1;
        i_valid = 1; i_memread = rd; i_memwrite = wr; i_size = 2'(sz); i_unsigned = uns;
        i_alures = addr; i_wdata = wdata; i_WB = wb; i_we = we; mem_ack = 0;
        @(negedge clk);
        if (o_stall) stalls++;
        check("issue_wb", o_WB, 0);
        check("issue_req", mem_req, 0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            mem_ack   = (k == ack_at);
            mem_rdata = (k == ack_at) ? rdata : $urandom;
            @(negedge clk);
            if (o_stall) stalls++;
            check("req_req", mem_req, 1);
            check("req_wb", o_WB, 0);
            check("req_addr", mem_addr, addr & 32'hFFFFFFFC);
            check("req_be", mem_be, exp_be(sz, addr));
            check("req_wr", mem_wr, wr);
            if (wr) check("req_wdata", mem_wdata, exp_wdata(sz, wdata));
            if (k == ack_at || k == 14) break;
        end
        @(posedge clk); #1;
        mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        @(negedge clk);
        if (o_stall) stalls++;
        check("resp_req", mem_req, 0);
        check("resp_wb", o_WB, tmo ? 2'b00 : wb);
        check("resp_buserr", o_buserr, tmo);
        check("resp_alures", o_alures, addr);
        check("resp_we", o_we, we);
        if (tmo || !wr) check("resp_data", o_dataread, tmo ? 32'd0 : exp_load(rdata, sz, uns, addr));
        check("stall_cycles", stalls, tmo ? 16 : 2 + ack_at);
        @(posedge clk); #1;
        i_valid = 0; i_memread = 1'($urandom); mem_ack = 1'($urandom); i_WB = 2'($urandom);
        @(negedge clk);
        check("back_req", mem_req, 0);
        check("back_stall", o_stall, 0);
        check("back_buserr", o_buserr, 0);
        check("back_wb", o_WB, i_WB);
        check("back_data", o_dataread, 0);
        mem_ack = 0;
        n_txn++;
        $display("txn %0d: %s size=%0d uns=%0d addr=%08h wdata=%08h rdata=%08h ack_at=%0d",
                 n_txn, wr ? "store" : "load", sz, uns, addr, wdata, rdata, ack_at);
    endtask

    // Non-memory cycle: everything passes straight through, bus stays idle
    task automatic run_passthru();
        @(posedge clk); #1;
        i_valid = 1'($urandom);
        if (i_valid) begin
            i_memread = 0; i_memwrite = 0;
        end else begin
            i_memread = 1'($urandom); i_memwrite = 1'($urandom);
        end
        i_alures = $urandom; i_WB = 2'($urandom); i_we = 5'($urandom);
        mem_ack = 1'($urandom); mem_rdata = $urandom;
        @(negedge clk);
        check("pt_stall", o_stall, 0);
        check("pt_req", mem_req, 0);
        check("pt_wb", o_WB, i_WB);
        check("pt_alures", o_alures, i_alures);
        check("pt_we", o_we, i_we);
        check("pt_data", o_dataread, 0);
        n_txn++;
        $display("txn %0d: passthru valid=%0d alures=%08h wb=%0d we=%0d",
                 n_txn, i_valid, i_alures, i_WB, i_we);
        i_valid = 0; mem_ack = 0;
    endtask

    initial begin
        int sz, ack_at, quiet_bad;
        bit wr, rd;
        logic [31:0] addr;

        idle_inputs();
        rst = 1;
        #1;
        check("rst_req", mem_req, 0);
        check("rst_wr", mem_wr, 0);
        check("rst_be", mem_be, 0);
        check("rst_buserr", o_buserr, 0);
        check("rst_misalign", o_misalign, 0);
        repeat (3) @(negedge clk);
        rst = 0;

        // Word load, ack on first REQ cycle
        run_mem(0, 1, 2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2'b11, 5'd7);
        // Signed / unsigned byte load from the top lane
        run_mem(0, 1, 0, 0, 32'h103, 32'h0, 32'h80000000, 0, 2'b01, 5'd3);
        run_mem(0, 1, 0, 1, 32'h103, 32'h0, 32'h80000000, 1, 2'b01, 5'd3);
        // Half store to the upper half
        run_mem(1, 0, 1, 0, 32'h102, 32'h1234ABCD, 32'h0, 0, 2'b10, 5'd0);
        // Read and write together: the write wins
        run_mem(1, 1, 0, 0, 32'h201, 32'h000000A5, 32'h0, 2, 2'b10, 5'd0);
        // No ack at all: bus error after 15 REQ cycles
        run_mem(0, 1, 2, 0, 32'h300, 32'h0, 32'h12345678, 15, 2'b11, 5'd9);

`ifdef MEM_ALIGN_CHECK_EN
        @(posedge clk); #1;
        i_valid = 1; i_memread = 1; i_memwrite = 0; i_size = 2'd2; i_alures = 32'h101; i_WB = 2'b11;
        @(negedge clk);
        check("ma_stall", o_stall, 0);
        check("ma_wb", o_WB, 0);
        check("ma_req", mem_req, 0);
        @(posedge clk); #1;
        i_valid = 0;
        @(negedge clk);
        check("ma_pulse", o_misalign, 1);
        check("ma_req2", mem_req, 0);
        @(negedge clk);
        check("ma_pulse_end", o_misalign, 0);
        check("ma_req3", mem_req, 0);
`else
        // Misaligned word load proceeds as an aligned word access
        run_mem(0, 1, 2, 0, 32'h101, 32'h0, 32'hCAFEF00D, 1, 2'b01, 5'd4);
        check("ma_tied", o_misalign, 0);
`endif

        // Reset in the middle of a store request
        @(posedge clk); #1;
        i_valid = 1; i_memread = 0; i_memwrite = 1; i_size = 2'd2; i_alures = 32'h400;
        i_wdata = 32'h55AA55AA; i_WB = 2'b00;
        @(posedge clk); #1;
        check("rst_mid_pre", mem_req, 1);
        #2;
        rst = 1; i_valid = 0; i_memwrite = 0;
        #1;
        check("rst_mid_req", mem_req, 0);
        check("rst_mid_wr", mem_wr, 0);
        check("rst_mid_be", mem_be, 0);
        check("rst_mid_stall", o_stall, 0);
        check("rst_mid_buserr", o_buserr, 0);
        @(negedge clk);
        rst = 0;
        quiet_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_buserr || mem_req || o_stall) quiet_bad++;
        end
        check("rst_quiet", quiet_bad, 0);
        run_passthru();

        // Randomized mix of accesses and pass-through cycles
        for (int t = 0; t < 40; t++) begin
            sz   = $urandom_range(0, 2);
            wr   = 1'($urandom);
            rd   = wr ? 1'($urandom) : 1'b1;
            addr = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
            if (sz == 2) addr = addr & 32'hFFFFFFFC;
            if (sz == 1) addr = addr & 32'hFFFFFFFE;
`endif
            ack_at = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 4)) : 15;
            run_mem(wr, rd, sz, 1'($urandom), addr, $urandom, $urandom, ack_at,
                    2'($urandom), 5'($urandom));
            if ($urandom_range(0, 1) == 1) run_passthru();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
